// File: rtl/div_fifo_bridge_if.sv
// div_fifo_bridge_if: operand write port, downstream
// credit input and result strobe of the divider stage.
interface div_fifo_bridge_if #(
    parameter int W     = 8,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic            wr_req;
    logic [2*W-1:0]  wr_data;
    logic [LW-1:0]   left;
    logic [LW-1:0]   dn_left;
    logic [2*W-1:0]  result;
    logic            done;
    logic            err_zero;

    modport master (
        output wr_req, wr_data, dn_left,
        input  left, result, done, err_zero
    );

    modport slave (
        input  wr_req, wr_data, dn_left,
        output left, result, done, err_zero
    );
endinterface

// File: rtl/div_fifo_bridge.sv
// div_fifo_bridge: FIFO-fed W-bit restoring divider.
// Optional macro DIV_ZERO_DETECT_EN: zero-divisor fast path.
module div_fifo_bridge #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    div_fifo_bridge_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, OUT} state_t;

    state_t          state, state_nx;
    logic [2*W-1:0]  mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [LW-1:0]   count;
    logic            push, pop;
    logic [2*W-1:0]  pop_data;
    logic [W-1:0]    dvd, dvs, rem;
    logic [IW-1:0]   iter;
    logic [W:0]      tmp, diff;
    logic            borrow;
    logic [2*W-1:0]  result_q;
    logic            done_q;
    logic            zero_in;

    // Both decisions use the count before the edge.
    assign push = bus.wr_req && (count != LW'(DEPTH));
    assign pop  = (state == IDLE) && (count != '0);

    assign bus.left   = LW'(DEPTH) - count;
    assign bus.result = result_q;
    assign bus.done   = done_q;

    assign zero_in = (pop_data[W-1:0] == '0);

    // One restoring step: shift in next dividend bit, trial subtract.
    assign tmp    = {rem, dvd[W-1]};
    assign diff   = tmp - {1'b0, dvs};
    assign borrow = diff[W];

    // FIFO storage and the popped-pair holding register.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= bus.wr_data;
        if (pop)
            pop_data <= mem[rptr];
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (pop) state_nx = LOAD;
`ifdef DIV_ZERO_DETECT_EN
            LOAD: state_nx = zero_in ? OUT : DIV;
`else
            LOAD: state_nx = DIV;
`endif
            DIV:  if (iter == IW'(W - 1)) state_nx = OUT;
            OUT:  if (bus.dn_left != '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Division datapath and registered result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            iter     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                LOAD: begin
                    dvd  <= pop_data[2*W-1:W];
                    dvs  <= pop_data[W-1:0];
                    rem  <= '0;
                    iter <= '0;
`ifdef DIV_ZERO_DETECT_EN
                    if (zero_in) begin
                        dvd <= '1;
                        rem <= pop_data[2*W-1:W];
                    end
`endif
                end
                DIV: begin
                    rem  <= borrow ? tmp[W-1:0] : diff[W-1:0];
                    dvd  <= {dvd[W-2:0], ~borrow};
                    iter <= iter + 1'b1;
                end
                OUT: begin
                    if (bus.dn_left != '0) begin
                        result_q <= {dvd, rem};
                        done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic zflag, err_q;

    assign bus.err_zero = err_q;

    // Remember a zero divisor and flag it alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zflag <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state == LOAD)
                zflag <= zero_in;
            if (state == OUT && bus.dn_left != '0)
                err_q <= zflag;
        end
    end
`else
    assign bus.err_zero = 1'b0;
`endif
endmodule
